// File: rtl/imem_boot_loader.sv
// Boot loader: turns a little-endian byte stream (32-bit word count + image) into
// instruction-memory writes, then releases the CPU once the last word is written.
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_start,
    output logic              busy,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [1:0] S_HDR  = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [1:0]      byte_cnt;
    logic [23:0]     asm_q;     // bytes 0..2 of the header or of the current word
    logic [ADDR_W:0] n_words;

    logic        accept;
    logic        last_byte;
    logic [31:0] full_word;
    logic        stream_on;

    assign accept    = rx_valid && rx_ready;
    assign last_byte = (byte_cnt == 2'd3);
    assign full_word = {rx_data, asm_q};
    assign stream_on = (state_nx == S_HDR) || (state_nx == S_LOAD);

    // NOTE: state_nx gets its default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        if (accept && last_byte) begin
            case (state)
                S_HDR: begin
                    if (full_word == 32'd0)
                        state_nx = S_DONE;
                    else if ({1'b0, full_word} > MAX_WORDS)
                        state_nx = S_ERR;
                    else
                        state_nx = S_LOAD;
                end
                S_LOAD: begin
                    if (words_loaded + 1'b1 == n_words)
                        state_nx = S_DONE;
                end
                default: state_nx = state;
            endcase
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state        <= S_HDR;
            byte_cnt     <= 2'd0;
            asm_q        <= 24'd0;
            n_words      <= '0;
            rx_ready     <= 1'b0;
            busy         <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            cpu_start    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            state     <= state_nx;
            rx_ready  <= stream_on;
            busy      <= stream_on;
            imem_we   <= 1'b0;
            // DONE is entered on the final write edge, so this lands one edge later.
            cpu_start <= cpu_start | (state == S_DONE);
            load_err  <= load_err | (state_nx == S_ERR);

            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    asm_q[7:0]   <= rx_data;
                    2'd1:    asm_q[15:8]  <= rx_data;
                    2'd2:    asm_q[23:16] <= rx_data;
                    default: asm_q        <= asm_q;
                endcase
                if (last_byte) begin
                    if (state == S_HDR) begin
                        n_words <= full_word[ADDR_W:0];
                    end else if (state == S_LOAD) begin
                        imem_we      <= 1'b1;
                        imem_addr    <= words_loaded[ADDR_W-1:0];
                        imem_wdata   <= full_word;
                        words_loaded <= words_loaded + 1'b1;
                    end
                end
            end
        end
    end

endmodule
